// File: rtl/fifo_ctrl_fsm.sv
// Main control FSM for the FIFO subsystem: power-up sequencing, threshold capture, idle/error reporting.
// Optional macro FSM_ERROR_RECOVERY_EN lets init leave ERROR; undefined, ERROR is left only by reset.
module fifo_ctrl_fsm #(
   parameter int NUM_FIFOS = 4,
   parameter int UMBRAL_W  = 3,
   parameter int DEF_SUP   = 6,
   parameter int DEF_INF   = 1
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 init,
   input  logic [UMBRAL_W-1:0]  umbral_superior_in,
   input  logic [UMBRAL_W-1:0]  umbral_inferior_in,
   input  logic [NUM_FIFOS-1:0] fifo_empty,
   input  logic [NUM_FIFOS-1:0] fifo_error,
   output logic [3:0]           state,
   output logic [UMBRAL_W-1:0]  um_sup,
   output logic [UMBRAL_W-1:0]  um_inf,
   output logic                 idle_out,
   output logic [NUM_FIFOS-1:0] error_out
);

   localparam logic [3:0] ST_RESET  = 4'd0;
   localparam logic [3:0] ST_INIT   = 4'd1;
   localparam logic [3:0] ST_IDLE   = 4'd2;
   localparam logic [3:0] ST_ACTIVE = 4'd3;
   localparam logic [3:0] ST_ERROR  = 4'd4;

   logic [3:0]           state_q, state_d;
   logic [UMBRAL_W-1:0]  sup_q, sup_d;
   logic [UMBRAL_W-1:0]  inf_q, inf_d;
   logic [NUM_FIFOS-1:0] err_q, err_d;
   logic                 any_err;
   logic                 all_empty;
   logic                 pair_ok;

   assign any_err   = |fifo_error;
   assign all_empty = &fifo_empty;
   assign pair_ok   = umbral_inferior_in < umbral_superior_in;

   always_comb begin
      state_d = state_q;
      sup_d   = sup_q;
      inf_d   = inf_q;
      err_d   = err_q;
      case (state_q)
         ST_RESET: state_d = ST_INIT;
         ST_INIT: begin
            // Thresholds are taken as a pair or not at all, even on the exit edge.
            if (pair_ok) begin
               sup_d = umbral_superior_in;
               inf_d = umbral_inferior_in;
            end
            if (any_err) begin
               state_d = ST_ERROR;
               err_d   = fifo_error;
            end else if (!init) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (any_err) begin
               state_d = ST_ERROR;
               err_d   = fifo_error;
            end else if (init) begin
               state_d = ST_INIT;
            end else if (!all_empty) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (any_err) begin
               state_d = ST_ERROR;
               err_d   = fifo_error;
            end else if (init) begin
               state_d = ST_INIT;
            end else if (all_empty) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERROR: begin
            err_d = err_q | fifo_error;
`ifdef FSM_ERROR_RECOVERY_EN
            if (init && !any_err) begin
               state_d = ST_INIT;
               err_d   = '0;
            end
`endif
         end
         default: state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q <= ST_RESET;
         sup_q   <= UMBRAL_W'(DEF_SUP);
         inf_q   <= UMBRAL_W'(DEF_INF);
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         sup_q   <= sup_d;
         inf_q   <= inf_d;
         err_q   <= err_d;
      end
   end

   assign state     = state_q;
   assign um_sup    = sup_q;
   assign um_inf    = inf_q;
   assign error_out = err_q;
   assign idle_out  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Directed bench for fifo_ctrl_fsm: driver pushes expected post-edge outputs, monitor pops and compares.
// Expected-output packing: {state[3:0], um_sup[2:0], um_inf[2:0], idle_out, error_out[3:0]}.
module tb_fifo_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       init = 1'b0;
   logic [2:0] umbral_superior_in = '0;
   logic [2:0] umbral_inferior_in = '0;
   logic [3:0] fifo_empty = 4'hF;
   logic [3:0] fifo_error = '0;
   logic [3:0] state;
   logic [2:0] um_sup;
   logic [2:0] um_inf;
   logic       idle_out;
   logic [3:0] error_out;

   logic [14:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;

   fifo_ctrl_fsm dut (
      .clk                (clk),
      .reset_L            (reset_L),
      .init               (init),
      .umbral_superior_in (umbral_superior_in),
      .umbral_inferior_in (umbral_inferior_in),
      .fifo_empty         (fifo_empty),
      .fifo_error         (fifo_error),
      .state              (state),
      .um_sup             (um_sup),
      .um_inf             (um_inf),
      .idle_out           (idle_out),
      .error_out          (error_out)
   );

   always #5 clk = ~clk;

   // Monitor: each vector's response is sampled 1 time unit after the edge it was set up for.
   always @(posedge clk) begin
      logic [14:0] act;
      logic [14:0] exp_v;
      string       nm;
      #1;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         nm    = name_q.pop_front();
         act   = {state, um_sup, um_inf, idle_out, error_out};
         checks++;
         if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got state=%0d sup=%0d inf=%0d idle=%b err=%b, want state=%0d sup=%0d inf=%0d idle=%b err=%b",
                     nm, act[14:11], act[10:8], act[7:5], act[4], act[3:0],
                     exp_v[14:11], exp_v[10:8], exp_v[7:5], exp_v[4], exp_v[3:0]);
         end
      end
   end

   task automatic step(input logic rst_n, input logic in_init, input logic [2:0] sup_in,
                       input logic [2:0] inf_in, input logic [3:0] empty, input logic [3:0] err,
                       input logic [3:0] e_state, input logic [2:0] e_sup, input logic [2:0] e_inf,
                       input logic [3:0] e_err, input string nm);
      @(negedge clk);
      reset_L            = rst_n;
      init               = in_init;
      umbral_superior_in = sup_in;
      umbral_inferior_in = inf_in;
      fifo_empty         = empty;
      fifo_error         = err;
      exp_q.push_back({e_state, e_sup, e_inf, (e_state == 4'd2), e_err});
      name_q.push_back(nm);
   endtask

   initial begin
      // Reset and defaults
      step(0, 0, 0, 0, 4'hF, 0, 0, 6, 1, 0, "reset_0");
      step(0, 0, 0, 0, 4'hF, 0, 0, 6, 1, 0, "reset_1");
      step(1, 0, 0, 0, 4'hF, 0, 1, 6, 1, 0, "release_init");
      step(1, 0, 0, 0, 4'hF, 0, 2, 6, 1, 0, "first_idle");
      // Threshold capture
      step(1, 1, 0, 0, 4'hF, 0, 1, 6, 1, 0, "idle_to_init");
      step(1, 1, 5, 2, 4'hF, 0, 1, 5, 2, 0, "capture_5_2");
      step(1, 1, 3, 3, 4'hF, 0, 1, 5, 2, 0, "equal_pair_hold");
      step(1, 1, 2, 4, 4'hF, 0, 1, 5, 2, 0, "invalid_pair_hold");
      step(1, 0, 2, 4, 4'hF, 0, 2, 5, 2, 0, "init_drop_idle");
      // Activity tracking and ping-pong
      step(1, 0, 7, 0, 4'b1011, 0, 3, 5, 2, 0, "active_1");
      step(1, 0, 7, 0, 4'b1011, 0, 3, 5, 2, 0, "active_2");
      step(1, 0, 7, 0, 4'b1011, 0, 3, 5, 2, 0, "active_3");
      step(1, 0, 7, 0, 4'hF,    0, 2, 5, 2, 0, "back_idle");
      step(1, 0, 7, 0, 4'b1110, 0, 3, 5, 2, 0, "pingpong_a1");
      step(1, 0, 7, 0, 4'hF,    0, 2, 5, 2, 0, "pingpong_i1");
      step(1, 0, 7, 0, 4'b0111, 0, 3, 5, 2, 0, "pingpong_a2");
      step(1, 1, 7, 0, 4'b0111, 0, 1, 5, 2, 0, "active_init_wins");
      step(1, 0, 5, 2, 4'hF,    0, 2, 5, 2, 0, "init_exit_same");
      // Reset mid-operation, then INIT exit with a valid pair on the same edge
      step(1, 0, 0, 0, 4'b1011, 0, 3, 5, 2, 0, "active_pre_reset");
      step(0, 0, 0, 0, 4'b1011, 0, 0, 6, 1, 0, "mid_reset");
      step(1, 1, 0, 0, 4'b1011, 0, 1, 6, 1, 0, "reset_to_init");
      step(1, 0, 5, 2, 4'hF,    0, 2, 5, 2, 0, "init_exit_capture");
      // Error capture from ACTIVE
      step(1, 0, 0, 0, 4'b1011, 0,       3, 5, 2, 4'b0000, "pre_error_active");
      step(1, 0, 0, 0, 4'b1011, 4'b0010, 4, 5, 2, 4'b0010, "error_entry");
      step(1, 0, 0, 0, 4'b1011, 4'b0000, 4, 5, 2, 4'b0010, "error_hold");
      step(1, 0, 0, 0, 4'b1011, 4'b1000, 4, 5, 2, 4'b1010, "error_sticky");
`ifdef FSM_ERROR_RECOVERY_EN
      step(1, 1, 0, 0, 4'hF,    4'b0000, 1, 5, 2, 4'b0000, "recover_to_init");
`else
      step(1, 1, 0, 0, 4'hF,    4'b0000, 4, 5, 2, 4'b1010, "init_ignored_err");
`endif
      // Error and init together from IDLE; reset ignores a pending error
      step(0, 0, 0, 0, 4'hF, 0,       0, 6, 1, 0, "reset_2");
      step(1, 0, 0, 0, 4'hF, 4'b0010, 1, 6, 1, 0, "reset_ignores_err");
      step(1, 0, 0, 0, 4'hF, 0,       2, 6, 1, 0, "idle_again");
      step(1, 1, 0, 0, 4'hF, 4'b0001, 4, 6, 1, 4'b0001, "err_beats_init");
      step(1, 1, 0, 0, 4'hF, 4'b0100, 4, 6, 1, 4'b0101, "err_init_stay");
`ifdef FSM_ERROR_RECOVERY_EN
      step(1, 1, 0, 0, 4'hF, 4'b0000, 1, 6, 1, 4'b0000, "recover_clear");
`else
      step(1, 1, 0, 0, 4'hF, 4'b0000, 4, 6, 1, 4'b0101, "error_terminal");
`endif
      step(1, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, "drain_marker");
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
